alu_issue_stage: RTL and testbench

//  ID/EX issue register feeding the ALU's a, b and op inputs; holds one instruction.

---
 rtl/alu_issue_stage_if.sv | 47 ++++
 rtl/alu_issue_stage.sv | 101 ++++++++++
 tb/tb_alu_issue_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decode-side handshake, forwarding taps, flush and the ALU-side handshake.
// master is the surrounding pipeline; slave is the issue stage itself.
interface alu_issue_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3,
    parameter int unsigned RA_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [RA_W-1:0]  in_rs_addr;
    logic [RA_W-1:0]  in_rt_addr;
    logic [WIDTH-1:0] in_rs_val;
    logic [WIDTH-1:0] in_rt_val;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [OP_W-1:0]  in_op;
    logic [RA_W-1:0]  in_rd_addr;
    logic             flush;
    logic             fwd_mem_valid;
    logic [RA_W-1:0]  fwd_mem_addr;
    logic [WIDTH-1:0] fwd_mem_data;
    logic             fwd_wb_valid;
    logic [RA_W-1:0]  fwd_wb_addr;
    logic [WIDTH-1:0] fwd_wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [RA_W-1:0]  out_rd_addr;

    modport master (
        output in_valid, in_rs_addr, in_rt_addr, in_rs_val, in_rt_val, in_imm, in_use_imm,
        output in_op, in_rd_addr, flush,
        output fwd_mem_valid, fwd_mem_addr, fwd_mem_data, fwd_wb_valid, fwd_wb_addr, fwd_wb_data,
        output out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd_addr
    );

    modport slave (
        input  in_valid, in_rs_addr, in_rt_addr, in_rs_val, in_rt_val, in_imm, in_use_imm,
        input  in_op, in_rd_addr, flush,
        input  fwd_mem_valid, fwd_mem_addr, fwd_mem_data, fwd_wb_valid, fwd_wb_addr, fwd_wb_data,
        input  out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd_addr
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU: forwards MEM/WB results into operands a/b, keeps
// snooping the forwarding taps while stalled, and supports valid/ready backpressure and flush.
module alu_issue_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3,
    parameter int unsigned RA_W  = 5
) (
    input logic              clk,
    input logic              rst,
    alu_issue_stage_if.slave bus
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [RA_W-1:0]  rs_q, rs_d;
    logic [RA_W-1:0]  rt_q, rt_d;
    logic             use_imm_q, use_imm_d;
    logic             in_ready;
    logic             in_fire;

    // MEM is younger than WB, so it wins; r0 is hardwired and never forwarded.
    function automatic logic [WIDTH-1:0] fwd(input logic [RA_W-1:0]  addr,
                                             input logic [WIDTH-1:0] rf_val);
        logic [WIDTH-1:0] res;
        res = rf_val;
        if (addr != '0) begin
            if (bus.fwd_mem_valid && addr == bus.fwd_mem_addr) begin
                res = bus.fwd_mem_data;
            end else if (bus.fwd_wb_valid && addr == bus.fwd_wb_addr) begin
                res = bus.fwd_wb_data;
            end
        end
        return res;
    endfunction

    always_comb begin
        in_ready  = !bus.flush && (!valid_q || bus.out_ready);
        in_fire   = bus.in_valid && in_ready;
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        use_imm_d = use_imm_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d   = 1'b1;
            a_d       = fwd(bus.in_rs_addr, bus.in_rs_val);
            b_d       = bus.in_use_imm ? bus.in_imm : fwd(bus.in_rt_addr, bus.in_rt_val);
            op_d      = bus.in_op;
            rd_d      = bus.in_rd_addr;
            rs_d      = bus.in_rs_addr;
            rt_d      = bus.in_rt_addr;
            use_imm_d = bus.in_use_imm;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: a producer retiring now must still reach the held operands.
            a_d = fwd(rs_q, a_q);
            if (!use_imm_q) begin
                b_d = fwd(rt_q, b_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_W'(1);
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_op      = op_q;
    assign bus.out_rd_addr = rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic, all checked
// against a per-cycle model of the held instruction.
module tb_alu_issue_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_issue_stage_if #(.WIDTH(32), .OP_W(3), .RA_W(5)) bus ();

    alu_issue_stage #(.WIDTH(32), .OP_W(3), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the single held instruction.
    logic        m_valid;
    logic [31:0] m_a, m_b, m_imm;
    logic [2:0]  m_op;
    logic [4:0]  m_rd, m_rs, m_rt;
    logic        m_use_imm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] val);
        if (addr == 5'd0) return val;
        if (bus.fwd_mem_valid && bus.fwd_mem_addr == addr) return bus.fwd_mem_data;
        if (bus.fwd_wb_valid && bus.fwd_wb_addr == addr) return bus.fwd_wb_data;
        return val;
    endfunction

    // Called just after a falling edge with inputs already set; returns after the next one.
    task automatic step();
        logic        exp_ready, fire;
        logic        n_valid;
        logic [31:0] n_a, n_b;
        #1;
        exp_ready = !bus.flush && (!m_valid || bus.out_ready);
        if (!rst) check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        fire    = bus.in_valid && exp_ready;
        n_valid = m_valid;
        n_a     = m_a;
        n_b     = m_b;
        if (rst) begin
            n_valid = 1'b0;
        end else if (bus.flush) begin
            n_valid = 1'b0;
        end else if (fire) begin
            n_valid = 1'b1;
            n_a     = ref_fwd(bus.in_rs_addr, bus.in_rs_val);
            n_b     = bus.in_use_imm ? bus.in_imm : ref_fwd(bus.in_rt_addr, bus.in_rt_val);
        end else if (bus.out_ready) begin
            n_valid = 1'b0;
        end else if (m_valid) begin
            n_a = ref_fwd(m_rs, m_a);
            n_b = m_use_imm ? m_b : ref_fwd(m_rt, m_b);
        end
        @(posedge clk);
        if (rst) begin
            m_a  = 32'd0;
            m_b  = 32'd0;
            m_op = 3'd1;
            m_rd = 5'd0;
        end else begin
            m_a = n_a;
            m_b = n_b;
            if (fire) begin
                m_op      = bus.in_op;
                m_rd      = bus.in_rd_addr;
                m_rs      = bus.in_rs_addr;
                m_rt      = bus.in_rt_addr;
                m_use_imm = bus.in_use_imm;
                m_imm     = bus.in_imm;
            end
        end
        m_valid = n_valid;
        @(negedge clk);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("alu_a", bus.alu_a, m_a);
            check("alu_b", bus.alu_b, m_b);
            check("alu_op", {29'd0, bus.alu_op}, {29'd0, m_op});
            check("rd", {27'd0, bus.out_rd_addr}, {27'd0, m_rd});
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_rs_addr    = '0;
        bus.in_rt_addr    = '0;
        bus.in_rs_val     = '0;
        bus.in_rt_val     = '0;
        bus.in_imm        = '0;
        bus.in_use_imm    = 1'b0;
        bus.in_op         = '0;
        bus.in_rd_addr    = '0;
        bus.flush         = 1'b0;
        bus.fwd_mem_valid = 1'b0;
        bus.fwd_mem_addr  = '0;
        bus.fwd_mem_data  = '0;
        bus.fwd_wb_valid  = 1'b0;
        bus.fwd_wb_addr   = '0;
        bus.fwd_wb_data   = '0;
        bus.out_ready     = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rs_val,
                         input logic [31:0] rt_val, input logic [2:0] op, input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_rs_addr = rs;
        bus.in_rt_addr = rt;
        bus.in_rs_val  = rs_val;
        bus.in_rt_val  = rt_val;
        bus.in_op      = op;
        bus.in_rd_addr = rd;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_valid   = 1'b0;
        m_a       = '0;
        m_b       = '0;
        m_imm     = '0;
        m_op      = 3'd1;
        m_rd      = '0;
        m_rs      = '0;
        m_rt      = '0;
        m_use_imm = 1'b0;
        rst       = 1'b1;
        idle_inputs();
        @(negedge clk);
        step();
        rst = 1'b0;
        check("rst_a", bus.alu_a, 32'd0);
        check("rst_b", bus.alu_b, 32'd0);
        check("rst_op", {29'd0, bus.alu_op}, 32'd1);
        check("rst_rd", {27'd0, bus.out_rd_addr}, 32'd0);

        // Basic issue.
        issue(5'd1, 5'd2, 32'd5, 32'd7, 3'd0, 5'd9);
        step();
        check("basic_a", bus.alu_a, 32'd5);
        check("basic_b", bus.alu_b, 32'd7);
        check("basic_rd", {27'd0, bus.out_rd_addr}, 32'd9);
        idle_inputs();
        step();

        // MEM beats WB; r0 never forwarded.
        issue(5'd3, 5'd8, 32'h11, 32'h0, 3'd2, 5'd4);
        bus.fwd_mem_valid = 1'b1; bus.fwd_mem_addr = 5'd3; bus.fwd_mem_data = 32'hAA;
        bus.fwd_wb_valid  = 1'b1; bus.fwd_wb_addr  = 5'd3; bus.fwd_wb_data  = 32'hBB;
        step();
        check("prio_a", bus.alu_a, 32'hAA);
        issue(5'd0, 5'd8, 32'h22, 32'h0, 3'd3, 5'd4);
        bus.fwd_mem_addr = 5'd0;
        bus.fwd_wb_addr  = 5'd0;
        step();
        check("r0_a", bus.alu_a, 32'h22);
        idle_inputs();
        step();

        // Stall snoop on rt.
        issue(5'd5, 5'd4, 32'h3, 32'h1, 3'd0, 5'd7);
        bus.out_ready = 1'b0;
        step();
        bus.fwd_wb_valid = 1'b1; bus.fwd_wb_addr = 5'd4; bus.fwd_wb_data = 32'h55;
        step();
        check("snoop_b", bus.alu_b, 32'h55);
        check("snoop_ready", {31'd0, bus.in_ready}, 32'd0);
        idle_inputs();
        step();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Immediate ignores rt forwarding.
        issue(5'd1, 5'd6, 32'h9, 32'h2, 3'd0, 5'd3);
        bus.in_use_imm = 1'b1; bus.in_imm = 32'hFFFF_FFFC;
        bus.fwd_mem_valid = 1'b1; bus.fwd_mem_addr = 5'd6; bus.fwd_mem_data = 32'h1234;
        step();
        check("imm_b", bus.alu_b, 32'hFFFF_FFFC);
        idle_inputs();

        // Back-to-back issue, then flush.
        for (int i = 1; i <= 3; i++) begin
            issue(5'd2, 5'd3, 32'(i * 16), 32'(i), 3'(i), 5'(i));
            step();
            check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
            check("b2b_rd", {27'd0, bus.out_rd_addr}, 32'(i));
        end
        bus.flush = 1'b1;
        #1;
        check("flush_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        idle_inputs();

        // Reset while stalled.
        issue(5'd1, 5'd2, 32'h77, 32'h88, 3'd4, 5'd5);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst2_op", {29'd0, bus.alu_op}, 32'd1);
        check("rst2_a", bus.alu_a, 32'd0);
        check("rst2_b", bus.alu_b, 32'd0);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid      = ($urandom_range(0, 3) != 0);
            bus.in_rs_addr    = 5'($urandom_range(0, 7));
            bus.in_rt_addr    = 5'($urandom_range(0, 7));
            bus.in_rs_val     = $urandom;
            bus.in_rt_val     = $urandom;
            bus.in_imm        = $urandom;
            bus.in_use_imm    = 1'($urandom_range(0, 1));
            bus.in_op         = 3'($urandom_range(0, 7));
            bus.in_rd_addr    = 5'($urandom_range(0, 31));
            bus.flush         = ($urandom_range(0, 19) == 0);
            bus.fwd_mem_valid = 1'($urandom_range(0, 1));
            bus.fwd_mem_addr  = 5'($urandom_range(0, 7));
            bus.fwd_mem_data  = $urandom;
            bus.fwd_wb_valid  = 1'($urandom_range(0, 1));
            bus.fwd_wb_addr   = 5'($urandom_range(0, 7));
            bus.fwd_wb_data   = $urandom;
            bus.out_ready     = ($urandom_range(0, 9) < 6);
            rst               = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
